// File: rtl/flow_ctrl.sv
// flow_ctrl -- pipeline flow controller.
//
// Each cycle it decides the redirect (jump_flag_o / jump_addr_o) and the hold
// level (hold_flag_o) seen by pc_reg, if_id and id_ex. It merges redirects
// from execute and the interrupt controller, merges stall requests from
// execute, the bus arbiter and the interrupt controller, and runs the debugger
// halt / drain / resume sequence. Interrupts that arrive while halted are
// remembered and issued on resume. A watchdog flags bus stalls that never end.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-low reset
//   jump_flag_ex_i/addr      execute redirect request and target
//   int_assert_i/int_addr_i  clint redirect pulse and target
//   hold_flag_ex_i           execute multi-cycle stall
//   hold_flag_rib_i          bus arbiter stall
//   hold_flag_clint_i        clint CSR-write stall
//   jtag_halt_i              debugger halt request (level)
//   jtag_reset_flag_i        debugger synchronous core reset
//   jump_flag_o/jump_addr_o  redirect to pc_reg (address is 0 when no redirect)
//   hold_flag_o              0 none, 1 Hold_Pc, 2 Hold_If, 3 Hold_Id
//   halted_o                 core halted acknowledge
//   bus_timeout_o            one-cycle pulse when a bus stall lasts too long
module flow_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned BUS_TIMEOUT  = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_ex_i,
   input  logic [31:0] jump_addr_ex_i,
   input  logic        int_assert_i,
   input  logic [31:0] int_addr_i,
   input  logic        hold_flag_ex_i,
   input  logic        hold_flag_rib_i,
   input  logic        hold_flag_clint_i,
   input  logic        jtag_halt_i,
   input  logic        jtag_reset_flag_i,
   output logic        jump_flag_o,
   output logic [31:0] jump_addr_o,
   output logic [2:0]  hold_flag_o,
   output logic        halted_o,
   output logic        bus_timeout_o
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_RESUME = 2'd3
   } state_t;

   localparam logic [2:0]  HOLD_NONE  = 3'd0;
   localparam logic [2:0]  HOLD_PC    = 3'd1;
   localparam logic [2:0]  HOLD_ID    = 3'd3;
   localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
   localparam logic [15:0] WD_LAST    = 16'(BUS_TIMEOUT - 1);
   localparam logic [15:0] WD_SAT     = 16'(BUS_TIMEOUT);

   state_t      state_r, state_s;
   logic [3:0]  drain_cnt_r, drain_cnt_s;
   logic        int_pend_r, int_pend_s;
   logic [31:0] pend_addr_r, pend_addr_s;
   logic [15:0] wd_cnt_r;
   logic        bus_timeout_r;
   logic [2:0]  fsm_level_s;
   logic [2:0]  req_level_s;

   function automatic logic [2:0] max_level(input logic [2:0] a, input logic [2:0] b);
      return (a > b) ? a : b;
   endfunction

   // FSM, drain counter and pending-interrupt registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_RUN;
         drain_cnt_r <= 4'd0;
         int_pend_r  <= 1'b0;
         pend_addr_r <= 32'd0;
      end else begin
         state_r     <= state_s;
         drain_cnt_r <= drain_cnt_s;
         int_pend_r  <= int_pend_s;
         pend_addr_r <= pend_addr_s;
      end
   end

   // Next-state logic for the halt sequence and the interrupt latch.
   always_comb begin
      state_s     = state_r;
      drain_cnt_s = drain_cnt_r;
      int_pend_s  = int_pend_r;
      pend_addr_s = pend_addr_r;
      if (jtag_reset_flag_i) begin
         state_s     = ST_RUN;
         drain_cnt_s = 4'd0;
         int_pend_s  = 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (jtag_halt_i) begin
                  state_s     = ST_DRAIN;
                  drain_cnt_s = DRAIN_LOAD;
               end else begin
                  state_s     = ST_RUN;
               end
            end
            ST_DRAIN: begin
               // A withdrawn halt aborts the drain before the counter matters.
               if (!jtag_halt_i) begin
                  state_s     = ST_RUN;
                  drain_cnt_s = 4'd0;
               end else if (drain_cnt_r == 4'd0) begin
                  state_s     = ST_HALTED;
               end else begin
                  drain_cnt_s = drain_cnt_r - 4'd1;
               end
            end
            ST_HALTED: begin
               // The newest interrupt target wins if several arrive while halted.
               if (int_assert_i) begin
                  int_pend_s  = 1'b1;
                  pend_addr_s = int_addr_i;
               end else begin
                  int_pend_s  = int_pend_r;
               end
               if (!jtag_halt_i) begin
                  state_s = ST_RESUME;
               end else begin
                  state_s = ST_HALTED;
               end
            end
            ST_RESUME: begin
               state_s    = ST_RUN;
               int_pend_s = 1'b0;
            end
            default: begin
               state_s     = ST_RUN;
               drain_cnt_s = 4'd0;
               int_pend_s  = 1'b0;
            end
         endcase
      end
   end

   // Redirect selection, hold merge and halt acknowledge.
   always_comb begin
      jump_flag_o = 1'b0;
      jump_addr_o = 32'd0;
      fsm_level_s = HOLD_NONE;
      halted_o    = 1'b0;
      case (state_r)
         ST_RUN, ST_DRAIN: begin
            fsm_level_s = (state_r == ST_DRAIN) ? HOLD_PC : HOLD_NONE;
            // clint has already captured the epc, so its target beats execute.
            if (int_assert_i) begin
               jump_flag_o = 1'b1;
               jump_addr_o = int_addr_i;
            end else if (jump_flag_ex_i) begin
               jump_flag_o = 1'b1;
               jump_addr_o = jump_addr_ex_i;
            end else begin
               jump_flag_o = 1'b0;
            end
         end
         ST_HALTED: begin
            fsm_level_s = HOLD_ID;
            halted_o    = 1'b1;
         end
         ST_RESUME: begin
            if (int_assert_i) begin
               jump_flag_o = 1'b1;
               jump_addr_o = int_addr_i;
            end else if (int_pend_r) begin
               jump_flag_o = 1'b1;
               jump_addr_o = pend_addr_r;
            end else if (jump_flag_ex_i) begin
               jump_flag_o = 1'b1;
               jump_addr_o = jump_addr_ex_i;
            end else begin
               jump_flag_o = 1'b0;
            end
         end
         default: begin
            fsm_level_s = HOLD_NONE;
         end
      endcase

      req_level_s = max_level((hold_flag_ex_i | hold_flag_clint_i) ? HOLD_ID : HOLD_NONE,
                              hold_flag_rib_i ? HOLD_PC : HOLD_NONE);
      hold_flag_o = max_level(req_level_s, fsm_level_s);

      // A debugger reset freezes the whole front end and suppresses redirects.
      if (jtag_reset_flag_i) begin
         jump_flag_o = 1'b0;
         jump_addr_o = 32'd0;
         hold_flag_o = HOLD_ID;
      end else begin
         hold_flag_o = hold_flag_o;
      end
   end

   // Bus watchdog: counts consecutive bus-hold cycles, pulses once, then saturates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt_r      <= 16'd0;
         bus_timeout_r <= 1'b0;
      end else if (jtag_reset_flag_i) begin
         wd_cnt_r      <= 16'd0;
         bus_timeout_r <= 1'b0;
      end else if (hold_flag_rib_i) begin
         bus_timeout_r <= (wd_cnt_r == WD_LAST);
         if (wd_cnt_r < WD_SAT) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
         end else begin
            wd_cnt_r <= wd_cnt_r;
         end
      end else begin
         wd_cnt_r      <= 16'd0;
         bus_timeout_r <= 1'b0;
      end
   end

   assign bus_timeout_o = bus_timeout_r;

endmodule

// File: tb/tb_flow_ctrl.sv
// Testbench for flow_ctrl: reset checks, a vector table for the redirect and
// hold merge, hand-written halt/resume/watchdog/reset sequences, and a
// randomized run compared against a behavioural model.
module tb_flow_ctrl;

   localparam int DC = 3;
   localparam int BT = 8;

   logic        clk, rst;
   logic        jump_flag_ex_i;
   logic [31:0] jump_addr_ex_i;
   logic        int_assert_i;
   logic [31:0] int_addr_i;
   logic        hold_flag_ex_i, hold_flag_rib_i, hold_flag_clint_i;
   logic        jtag_halt_i, jtag_reset_flag_i;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic [2:0]  hold_flag_o;
   logic        halted_o, bus_timeout_o;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   flow_ctrl #(.DRAIN_CYCLES(DC), .BUS_TIMEOUT(BT)) dut (
      .clk(clk), .rst(rst),
      .jump_flag_ex_i(jump_flag_ex_i), .jump_addr_ex_i(jump_addr_ex_i),
      .int_assert_i(int_assert_i), .int_addr_i(int_addr_i),
      .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
      .hold_flag_clint_i(hold_flag_clint_i),
      .jtag_halt_i(jtag_halt_i), .jtag_reset_flag_i(jtag_reset_flag_i),
      .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
      .hold_flag_o(hold_flag_o), .halted_o(halted_o), .bus_timeout_o(bus_timeout_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        ex_j;
      logic [31:0] ex_a;
      logic        in_j;
      logic [31:0] in_a;
      logic        h_ex, h_rib, h_cl;
      logic        e_jf;
      logic [31:0] e_ja;
      logic [2:0]  e_hold;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      jump_flag_ex_i = 1'b0; jump_addr_ex_i = 32'd0;
      int_assert_i = 1'b0;   int_addr_i = 32'd0;
      hold_flag_ex_i = 1'b0; hold_flag_rib_i = 1'b0; hold_flag_clint_i = 1'b0;
      jtag_halt_i = 1'b0;    jtag_reset_flag_i = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
   endtask

   // Drive halt from RUN until the halted acknowledge should be up.
   task automatic go_halted();
      jtag_halt_i = 1'b1;
      repeat (DC + 1) tick();
      #1;
      chk("halted_reached", 64'(halted_o), 64'd1);
   endtask

   // ---------------- behavioural reference model ----------------
   int          m_held;     // cycles a halt request has been pending while draining
   bit          m_halted, m_resume, m_bto;
   logic [31:0] m_pend[$];  // interrupt targets collected while halted
   int          m_run;      // consecutive bus-hold cycles seen so far

   task automatic model_reset();
      m_held = 0; m_halted = 0; m_resume = 0; m_bto = 0; m_run = 0;
      m_pend.delete();
   endtask

   function automatic logic [37:0] model_out();
      logic        jf;
      logic [31:0] ja;
      int          lvl, h;
      jf = 1'b0; ja = 32'd0;
      lvl = m_halted ? 3 : ((!m_resume && m_held > 0) ? 1 : 0);
      h = lvl;
      if (hold_flag_rib_i && h < 1) h = 1;
      if (hold_flag_ex_i || hold_flag_clint_i) h = 3;
      if (jtag_reset_flag_i) h = 3;
      if (jtag_reset_flag_i || m_halted) begin
         jf = 1'b0;
      end else if (int_assert_i) begin
         jf = 1'b1; ja = int_addr_i;
      end else if (m_resume && m_pend.size() > 0) begin
         jf = 1'b1; ja = m_pend[$];
      end else if (jump_flag_ex_i) begin
         jf = 1'b1; ja = jump_addr_ex_i;
      end
      return {jf, ja, 3'(h), m_halted, m_bto};
   endfunction

   task automatic model_step();
      if (jtag_reset_flag_i) begin
         model_reset();
      end else begin
         m_bto = hold_flag_rib_i && (m_run == BT - 1);
         m_run = hold_flag_rib_i ? m_run + 1 : 0;
         if (m_resume) begin
            m_resume = 0;
            m_pend.delete();
         end else if (m_halted) begin
            if (int_assert_i) m_pend.push_back(int_addr_i);
            if (!jtag_halt_i) begin m_halted = 0; m_resume = 1; end
         end else if (m_held > 0) begin
            if (!jtag_halt_i) m_held = 0;
            else if (m_held == DC) begin m_halted = 1; m_held = 0; end
            else m_held++;
         end else if (jtag_halt_i) begin
            m_held = 1;
         end
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h2000, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    3'd0};
      vecs[1] = '{1'b1, 32'h2000, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  3'd0};
      vecs[2] = '{1'b1, 32'h2000, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 3'd0};
      vecs[3] = '{1'b0, 32'h2000, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300,  3'd0};
      vecs[4] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    3'd3};
      vecs[5] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    3'd1};
      vecs[6] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    3'd3};
      vecs[7] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    3'd3};
      vecs[8] = '{1'b1, 32'h44,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 32'h44,   3'd3};
      vecs[9] = '{1'b0, 32'h5555, 1'b0, 32'h7777,1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    3'd0};

      rst = 1'b1;
      do_reset();

      // Reset release with idle inputs.
      for (int i = 0; i < 10; i++) begin
         chk("rst_hold", 64'(hold_flag_o), 64'd0);
         chk("rst_jump", 64'(jump_flag_o), 64'd0);
         chk("rst_halted", 64'(halted_o), 64'd0);
         chk("rst_bto", 64'(bus_timeout_o), 64'd0);
         tick();
      end

      // Redirect and hold merge table, all in RUN.
      for (int i = 0; i < 10; i++) begin
         jump_flag_ex_i = vecs[i].ex_j; jump_addr_ex_i = vecs[i].ex_a;
         int_assert_i = vecs[i].in_j;   int_addr_i = vecs[i].in_a;
         hold_flag_ex_i = vecs[i].h_ex; hold_flag_rib_i = vecs[i].h_rib;
         hold_flag_clint_i = vecs[i].h_cl;
         #1;
         chk($sformatf("vec%0d_jf", i), 64'(jump_flag_o), 64'(vecs[i].e_jf));
         chk($sformatf("vec%0d_ja", i), 64'(jump_addr_o), 64'(vecs[i].e_ja));
         chk($sformatf("vec%0d_hold", i), 64'(hold_flag_o), 64'(vecs[i].e_hold));
         tick();
      end
      idle();
      tick();

      // Halt latency: Hold_Pc for DC cycles, then halted with Hold_Id.
      jtag_halt_i = 1'b1;
      #1;
      chk("halt_n_hold", 64'(hold_flag_o), 64'd0);
      for (int i = 1; i <= DC; i++) begin
         tick();
         chk($sformatf("drain%0d_hold", i), 64'(hold_flag_o), 64'd1);
         chk($sformatf("drain%0d_halted", i), 64'(halted_o), 64'd0);
      end
      tick();
      chk("halted_ack", 64'(halted_o), 64'd1);
      chk("halted_hold", 64'(hold_flag_o), 64'd3);
      // Interrupt while halted is held back, execute jump ignored.
      int_assert_i = 1'b1; int_addr_i = 32'h40; jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h2000;
      #1;
      chk("halted_no_redirect", 64'(jump_flag_o), 64'd0);
      tick();
      int_assert_i = 1'b0; jump_flag_ex_i = 1'b0;
      jtag_halt_i = 1'b0;
      #1;
      chk("release_still_halted", 64'(halted_o), 64'd1);
      tick();
      chk("resume_jf", 64'(jump_flag_o), 64'd1);
      chk("resume_ja", 64'(jump_addr_o), 64'h40);
      chk("resume_halted", 64'(halted_o), 64'd0);
      chk("resume_hold", 64'(hold_flag_o), 64'd0);
      tick();
      chk("after_resume_jf", 64'(jump_flag_o), 64'd0);
      tick();

      // Drain abort: halt withdrawn during the drain.
      jtag_halt_i = 1'b1;
      tick(); tick();
      jtag_halt_i = 1'b0;
      #1;
      chk("abort_drain_hold", 64'(hold_flag_o), 64'd1);
      tick();
      chk("abort_run_hold", 64'(hold_flag_o), 64'd0);
      for (int i = 0; i < DC + 2; i++) begin
         chk("abort_never_halted", 64'(halted_o), 64'd0);
         tick();
      end

      // Watchdog: single pulse at K+BT, Hold_Pc throughout, rearm after drop.
      for (int r = 0; r < 2; r++) begin
         hold_flag_rib_i = 1'b1;
         #1;
         for (int c = 0; c < 20; c++) begin
            chk($sformatf("wd%0d_c%0d_bto", r, c), 64'(bus_timeout_o), 64'(c == BT));
            if (c == 0 || c == BT) chk("wd_hold", 64'(hold_flag_o), 64'd1);
            tick();
         end
         hold_flag_rib_i = 1'b0;
         tick();
         chk("wd_drop_bto", 64'(bus_timeout_o), 64'd0);
      end

      // Debugger reset while halted with an interrupt pending.
      go_halted();
      int_assert_i = 1'b1; int_addr_i = 32'h80;
      tick();
      int_assert_i = 1'b0;
      jtag_reset_flag_i = 1'b1; jtag_halt_i = 1'b0;
      #1;
      chk("jrst_jf", 64'(jump_flag_o), 64'd0);
      chk("jrst_hold", 64'(hold_flag_o), 64'd3);
      tick();
      jtag_reset_flag_i = 1'b0;
      #1;
      chk("jrst_next_halted", 64'(halted_o), 64'd0);
      chk("jrst_next_hold", 64'(hold_flag_o), 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("jrst_no_pending", 64'(jump_flag_o), 64'd0);
         tick();
      end

      // Asynchronous reset in the middle of a drain.
      jtag_halt_i = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("arst_hold", 64'(hold_flag_o), 64'd0);
      chk("arst_halted", 64'(halted_o), 64'd0);
      chk("arst_jf", 64'(jump_flag_o), 64'd0);
      chk("arst_ja", 64'(jump_addr_o), 64'd0);
      tick();
      idle();
      rst = 1'b1;
      tick();

      // Randomized run against the behavioural model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(9, 0) == 0) jtag_halt_i = ~jtag_halt_i;
         if ($urandom_range(11, 0) == 0) hold_flag_rib_i = ~hold_flag_rib_i;
         jump_flag_ex_i    = ($urandom_range(3, 0) == 0);
         jump_addr_ex_i    = $urandom;
         int_assert_i      = ($urandom_range(5, 0) == 0);
         int_addr_i        = $urandom;
         hold_flag_ex_i    = ($urandom_range(7, 0) == 0);
         hold_flag_clint_i = ($urandom_range(9, 0) == 0);
         jtag_reset_flag_i = ($urandom_range(49, 0) == 0);
         #1;
         chk($sformatf("rand_c%0d", c),
             64'({jump_flag_o, jump_addr_o, hold_flag_o, halted_o, bus_timeout_o}),
             64'(model_out()));
         model_step();
         tick();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
